forward_ctrl: RTL and testbench
===============================

// Module: forward_ctrl
// PURPOSE
//   Forwarding/hazard controller driving the data_mux_3 operand selects of the EX stage.
//   Keeps a shadow pipeline (EX, MEM, WB) of destination-register info fed from ID.
//   Resolves RAW hazards by forwarding, or by a one-cycle load-use stall; counts stalls.
//   Sits beside the ID/EX pipeline registers; selects go straight to the EX operand muxes.
// PARAMETERS
//   REG_W  5   register-index width
//   CNT_W  16  stall-counter width
// PORTS
//   clk         in   1      pipeline clock, rising edge
//   rst_n       in   1      asynchronous active-low reset
//   id_valid    in   1      ID holds a real instruction
//   id_rs       in   REG_W  ID source A index
//   id_rt       in   REG_W  ID source B index
//   id_dst      in   REG_W  ID destination index
//   id_wen      in   1      ID instruction writes the register file
//   id_load     in   1      ID instruction is a memory load
//   flush       in   1      branch taken in EX: discard the ID instruction
//   fwd_a_sel   out  2      EX operand A select: 0 regfile, 1 EX/MEM, 2 MEM/WB
//   fwd_b_sel   out  2      EX operand B select, same encoding
//   stall       out  1      hold PC and IF/ID; bubble into ID/EX
//   stall_count out  CNT_W  saturating count of stall cycles
// BEHAVIOUR
//   - State per stage S in {ex,mem,wb}: S_vld, S_rs, S_rt, S_dst, S_wen, S_load.
//   - Reset: every field 0, stall_count 0 -> fwd_a_sel = fwd_b_sel = 0, stall = 0.
//   - Every clock edge: wb <= mem; mem <= ex.
//     ex <= ID fields when id_valid & ~stall & ~flush; otherwise ex <= bubble (all fields 0).
//   - A stage "writes" when S_vld & S_wen & S_dst != 0. Index 0 is never forwarded and
//     never stalls.
//   - fwd_a_sel, combinational from registered state only (no input-to-output path):
//     = 1 if mem writes and mem_dst == ex_rs;
//     else 2 if wb writes and wb_dst == ex_rs; else 0.
//     MEM has priority over WB because it holds the newer value.
//   - fwd_b_sel: same rule using ex_rt.
//   - stall (combinational) = id_valid & ~flush & ex writes & ex_load
//     & (ex_dst == id_rs | ex_dst == id_rt).
//     It lasts exactly one cycle: the load then moves to mem, and a bubble enters ex.
//     The held instruction then receives sel = 2 on the following EX cycle.
//   - Flush and stall in the same cycle: flush wins; stall = 0, a bubble enters ex.
//   - The register file is write-before-read, so no ID-stage bypass is produced here.
//   - stall_count increments on each edge where stall = 1; it holds at 2^CNT_W-1.
//   - Reset asserted mid-operation clears all stages at once; the outputs drop to 0
//     asynchronously.
//   - Latency: producer in EX at cycle t -> a consumer entering EX at t+1 sees sel = 1;
//     at t+2 it sees sel = 2; at t+3 it sees sel = 0 (regfile).
// TESTING
//   1. Reset: hold rst_n = 0, drive random ID inputs -> sel 0/0, stall 0, count 0;
//      release -> still 0 until a valid instr.
//   2. Back-to-back ALU: add r3<-r1,r2 then sub r4<-r3,r3 -> sub in EX has
//      fwd_a_sel = fwd_b_sel = 1, stall 0.
//   3. Distance 2 and 3: write r5, one unrelated instr, read r5 -> sel 2; with two
//      unrelated instrs -> sel 0.
//   4. Load-use: lw r6 then add r7<-r6,r1 -> stall = 1 for exactly one cycle,
//      stall_count = 1, add in EX gets fwd_a_sel = 2.
//   5. Priority and r0: two writes to r8 in a row, then read r8 -> sel 1 (newest).
//      Writes to r0 followed by a read of r0 -> sel 0, no stall.
//   6. Flush during load-use: lw r9 in EX, dependent instr in ID with flush = 1 -> stall 0,
//      bubble in EX. With CNT_W = 2, four stalls -> count holds at 3.

Source files
------------

// File: rtl/forward_ctrl.sv
// forward_ctrl: EX-stage operand forwarding and load-use hazard control.
// Keeps a shadow copy of the destination-register info for the EX, MEM and
// WB stages. From that copy it picks the operand mux selects for the
// instruction in EX. It also raises a one-cycle stall when the instruction
// in ID needs the result of a load that is still in EX.
// MEM and WB only keep what forwarding needs (valid, write enable and
// destination). Their source indices and load flag are never consulted
// once an instruction has left EX.

module forward_ctrl #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic [REG_W-1:0] id_dst,
    input  logic             id_wen,
    input  logic             id_load,
    input  logic             flush,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             stall,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [REG_W-1:0] REG_ZERO = {REG_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    localparam logic [1:0] SEL_RF  = 2'd0;
    localparam logic [1:0] SEL_MEM = 2'd1;
    localparam logic [1:0] SEL_WB  = 2'd2;

    // EX stage shadow state
    logic             ex_vld_r;
    logic [REG_W-1:0] ex_rs_r;
    logic [REG_W-1:0] ex_rt_r;
    logic [REG_W-1:0] ex_dst_r;
    logic             ex_wen_r;
    logic             ex_load_r;

    // MEM stage shadow state
    logic             mem_vld_r;
    logic [REG_W-1:0] mem_dst_r;
    logic             mem_wen_r;

    // WB stage shadow state
    logic             wb_vld_r;
    logic [REG_W-1:0] wb_dst_r;
    logic             wb_wen_r;

    logic [CNT_W-1:0] stall_count_r;

    logic             ex_writes_s;
    logic             mem_writes_s;
    logic             wb_writes_s;
    logic             stall_s;
    logic             ex_load_s;
    logic [1:0]       fwd_a_s;
    logic [1:0]       fwd_b_s;

    // A stage produces a forwardable value only for a real write to a non-zero register
    function automatic logic stage_writes(input logic vld, input logic wen,
                                          input logic [REG_W-1:0] dst);
        return vld & wen & (dst != REG_ZERO);
    endfunction

    // Operand select for one source index; MEM holds the newer value so it wins over WB
    function automatic logic [1:0] pick_sel(input logic [REG_W-1:0] src,
                                            input logic mem_w, input logic [REG_W-1:0] mem_d,
                                            input logic wb_w,  input logic [REG_W-1:0] wb_d);
        logic [1:0] sel;
        if (mem_w && (mem_d == src)) begin
            sel = SEL_MEM;
        end else if (wb_w && (wb_d == src)) begin
            sel = SEL_WB;
        end else begin
            sel = SEL_RF;
        end
        return sel;
    endfunction

    assign ex_writes_s  = stage_writes(ex_vld_r,  ex_wen_r,  ex_dst_r);
    assign mem_writes_s = stage_writes(mem_vld_r, mem_wen_r, mem_dst_r);
    assign wb_writes_s  = stage_writes(wb_vld_r,  wb_wen_r,  wb_dst_r);
    assign ex_load_s    = ex_writes_s & ex_load_r;

    // Forward selects and load-use stall; selects depend on registered state only
    always_comb begin
        fwd_a_s = pick_sel(ex_rs_r, mem_writes_s, mem_dst_r, wb_writes_s, wb_dst_r);
        fwd_b_s = pick_sel(ex_rt_r, mem_writes_s, mem_dst_r, wb_writes_s, wb_dst_r);
        if (id_valid && !flush && ex_load_s &&
            ((ex_dst_r == id_rs) || (ex_dst_r == id_rt))) begin
            stall_s = 1'b1;
        end else begin
            stall_s = 1'b0;
        end
    end

    // Shadow pipeline advance: ID enters EX unless stalled/flushed, else a bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_vld_r  <= 1'b0;
            ex_rs_r   <= REG_ZERO;
            ex_rt_r   <= REG_ZERO;
            ex_dst_r  <= REG_ZERO;
            ex_wen_r  <= 1'b0;
            ex_load_r <= 1'b0;
            mem_vld_r <= 1'b0;
            mem_dst_r <= REG_ZERO;
            mem_wen_r <= 1'b0;
            wb_vld_r  <= 1'b0;
            wb_dst_r  <= REG_ZERO;
            wb_wen_r  <= 1'b0;
        end else begin
            wb_vld_r  <= mem_vld_r;
            wb_dst_r  <= mem_dst_r;
            wb_wen_r  <= mem_wen_r;
            mem_vld_r <= ex_vld_r;
            mem_dst_r <= ex_dst_r;
            mem_wen_r <= ex_wen_r;
            if (id_valid && !stall_s && !flush) begin
                ex_vld_r  <= 1'b1;
                ex_rs_r   <= id_rs;
                ex_rt_r   <= id_rt;
                ex_dst_r  <= id_dst;
                ex_wen_r  <= id_wen;
                ex_load_r <= id_load;
            end else begin
                ex_vld_r  <= 1'b0;
                ex_rs_r   <= REG_ZERO;
                ex_rt_r   <= REG_ZERO;
                ex_dst_r  <= REG_ZERO;
                ex_wen_r  <= 1'b0;
                ex_load_r <= 1'b0;
            end
        end
    end

    // Saturating count of stall cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count_r <= CNT_ZERO;
        end else if (stall_s && (stall_count_r != CNT_MAX)) begin
            stall_count_r <= stall_count_r + CNT_ONE;
        end else begin
            stall_count_r <= stall_count_r;
        end
    end

    assign fwd_a_sel   = fwd_a_s;
    assign fwd_b_sel   = fwd_b_s;
    assign stall       = stall_s;
    assign stall_count = stall_count_r;

endmodule

// File: tb/tb_forward_ctrl.sv
// tb_forward_ctrl: directed vectors for forward_ctrl with hand-computed expectations.
// Uses a 2-bit stall counter so that saturation is reachable.

module tb_forward_ctrl;

    localparam int REG_W = 5;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             id_valid;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic [REG_W-1:0] id_dst;
    logic             id_wen;
    logic             id_load;
    logic             flush;
    logic [1:0]       fwd_a_sel;
    logic [1:0]       fwd_b_sel;
    logic             stall;
    logic [CNT_W-1:0] stall_count;

    int n_tests = 0;
    int n_fail  = 0;

    forward_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_dst      (id_dst),
        .id_wen      (id_wen),
        .id_load     (id_load),
        .flush       (flush),
        .fwd_a_sel   (fwd_a_sel),
        .fwd_b_sel   (fwd_b_sel),
        .stall       (stall),
        .stall_count (stall_count)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input int rs, input int rt, input int dst,
                         input logic wen, input logic ld, input logic fl);
        id_valid = v;
        id_rs    = rs[REG_W-1:0];
        id_rt    = rt[REG_W-1:0];
        id_dst   = dst[REG_W-1:0];
        id_wen   = wen;
        id_load  = ld;
        flush    = fl;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one instruction from ID into EX
    task automatic instr(input int rs, input int rt, input int dst,
                         input logic wen, input logic ld);
        drive(1'b1, rs, rt, dst, wen, ld, 1'b0);
        tick();
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
            tick();
        end
    endtask

    task automatic check_sel(input string tag, input int a, input int b, input int st);
        check({tag, "_a"}, {30'd0, fwd_a_sel}, a);
        check({tag, "_b"}, {30'd0, fwd_b_sel}, b);
        check({tag, "_stall"}, {31'd0, stall}, st);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);

        // 1. Reset held with random ID traffic
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, $urandom_range(31), $urandom_range(31), $urandom_range(31),
                  1'b1, 1'b1, 1'b0);
            check_sel("rst", 0, 0, 0);
            check("rst_cnt", {30'd0, stall_count}, 0);
            tick();
        end
        rst_n = 1'b1;
        nops(1);
        check_sel("post_rst", 0, 0, 0);
        check("post_rst_cnt", {30'd0, stall_count}, 0);

        // 2. Back-to-back ALU: add r3<-r1,r2 ; sub r4<-r3,r3
        instr(1, 2, 3, 1'b1, 1'b0);
        drive(1'b1, 3, 3, 4, 1'b1, 1'b0, 1'b0);
        check("b2b_nostall", {31'd0, stall}, 0);
        tick();
        drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        check_sel("b2b", 1, 1, 0);
        nops(3);

        // 3. Distance 2 then distance 3 on r5
        instr(0, 0, 5, 1'b1, 1'b0);
        instr(11, 12, 10, 1'b1, 1'b0);
        instr(5, 13, 14, 1'b1, 1'b0);
        drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        check_sel("dist2", 2, 0, 0);
        nops(3);
        instr(0, 0, 5, 1'b1, 1'b0);
        instr(11, 12, 10, 1'b1, 1'b0);
        instr(11, 12, 15, 1'b1, 1'b0);
        instr(13, 5, 14, 1'b1, 1'b0);
        drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        check_sel("dist3", 0, 0, 0);
        nops(3);

        // 4. Load-use: lw r6 ; add r7<-r6,r1
        instr(1, 0, 6, 1'b1, 1'b1);
        drive(1'b1, 6, 1, 7, 1'b1, 1'b0, 1'b0);
        check("lu_stall1", {31'd0, stall}, 1);
        tick();
        check("lu_stall2", {31'd0, stall}, 0);
        check("lu_cnt", {30'd0, stall_count}, 1);
        tick();
        drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        check_sel("lu_fwd", 2, 0, 0);
        check("lu_cnt_hold", {30'd0, stall_count}, 1);
        nops(3);

        // 5. Priority: two writes to r8 then a read of r8
        instr(0, 0, 8, 1'b1, 1'b0);
        instr(0, 0, 8, 1'b1, 1'b0);
        instr(8, 8, 16, 1'b1, 1'b0);
        drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        check_sel("prio", 1, 1, 0);
        nops(3);

        // 5b. r0: load and ALU writes to r0, then reads of r0
        instr(1, 2, 0, 1'b1, 1'b0);
        instr(1, 2, 0, 1'b1, 1'b1);
        drive(1'b1, 0, 0, 17, 1'b1, 1'b0, 1'b0);
        check("r0_nostall", {31'd0, stall}, 0);
        tick();
        drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        check_sel("r0_sel", 0, 0, 0);
        nops(3);

        // 6. Flush during load-use: dependent (dst r20) is discarded
        instr(1, 0, 9, 1'b1, 1'b1);
        drive(1'b1, 9, 0, 20, 1'b1, 1'b0, 1'b1);
        check("flush_nostall", {31'd0, stall}, 0);
        tick();
        instr(20, 9, 21, 1'b1, 1'b0);
        drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        check_sel("flush_bubble", 0, 2, 0);
        check("flush_cnt", {30'd0, stall_count}, 1);
        nops(3);

        // 6b. Three more load-use stalls: count 2, 3, then holds at 3
        for (int k = 0; k < 3; k++) begin
            instr(1, 0, 22, 1'b1, 1'b1);
            drive(1'b1, 2, 22, 23, 1'b1, 1'b0, 1'b0);
            tick();
            tick();
            drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
            check("sat_cnt", {30'd0, stall_count}, (k + 2 > 3) ? 3 : k + 2);
            nops(3);
        end

        // Reset asserted mid-operation while a stall is pending
        instr(1, 0, 24, 1'b1, 1'b1);
        drive(1'b1, 24, 24, 25, 1'b1, 1'b0, 1'b0);
        check("mid_pre_stall", {31'd0, stall}, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_sel("mid_rst", 0, 0, 0);
        check("mid_rst_cnt", {30'd0, stall_count}, 0);
        tick();
        rst_n = 1'b1;
        nops(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
